// File: rtl/frame_framer.sv
// frame_framer: wraps the packed-pixel byte stream into frames of
// sync0, sync1, payload_bytes_p payload bytes and an 8-bit additive checksum.
// A single output register carries every byte; it reloads whenever it is free.
module frame_framer #(
  parameter int unsigned payload_bytes_p = 4800,
  parameter logic [7:0]  sync0_p         = 8'hA5,
  parameter logic [7:0]  sync1_p         = 8'h5A
) (
  input  logic       clk_i,
  input  logic       reset_ni,
  input  logic [7:0] data_i,
  input  logic       valid_i,
  output logic       ready_o,
  output logic [7:0] data_o,
  output logic       valid_o,
  input  logic       ready_i,
  output logic       frame_done_o
);

  localparam int unsigned CountW = $clog2(payload_bytes_p + 1);
  localparam logic [CountW-1:0] LastCount = CountW'(payload_bytes_p - 1);

  typedef enum logic [1:0] {HDR0, HDR1, PAY, CSUM} state_e;

  state_e            state_q, state_d;
  logic [CountW-1:0] count_q, count_d;
  logic [7:0]        sum_q, sum_d;
  logic [7:0]        data_q, data_d;
  logic              valid_q, valid_d;
  // Marks that the byte currently held in the output register is the checksum.
  logic              csum_q, csum_d;

  logic slot_free;
  logic out_fire;

  assign slot_free    = !valid_q || ready_i;
  assign out_fire     = valid_q && ready_i;
  assign ready_o      = (state_q == PAY) && slot_free;
  assign data_o       = data_q;
  assign valid_o      = valid_q;
  assign frame_done_o = out_fire && csum_q;

  // Next-state logic: one byte is loaded per slot-free cycle; otherwise hold.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    sum_d   = sum_q;
    data_d  = data_q;
    csum_d  = csum_q;
    // A held byte stays valid until it is accepted downstream.
    valid_d = valid_q && !ready_i;
    if (slot_free) begin
      unique case (state_q)
        HDR0: begin
          data_d  = sync0_p;
          valid_d = 1'b1;
          csum_d  = 1'b0;
          state_d = HDR1;
        end
        HDR1: begin
          data_d  = sync1_p;
          valid_d = 1'b1;
          csum_d  = 1'b0;
          sum_d   = '0;
          count_d = '0;
          state_d = PAY;
        end
        PAY: begin
          if (valid_i) begin
            data_d  = data_i;
            valid_d = 1'b1;
            csum_d  = 1'b0;
            sum_d   = sum_q + data_i;
            if (count_q == LastCount) begin
              count_d = '0;
              state_d = CSUM;
            end else begin
              count_d = count_q + CountW'(1);
            end
          end
        end
        CSUM: begin
          data_d  = sum_q;
          valid_d = 1'b1;
          csum_d  = 1'b1;
          state_d = HDR0;
        end
        default: state_d = HDR0;
      endcase
    end
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q <= HDR0;
      count_q <= '0;
      sum_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      csum_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      sum_q   <= sum_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      csum_q  <= csum_d;
    end
  end

endmodule

// File: tb/tb_frame_framer.sv
// Testbench for frame_framer: three instances (payload 4, 7 and 1 bytes),
// each checked against a per-instance queue of expected output bytes.
module tb_frame_framer;

  typedef struct packed {
    logic [7:0] b;
    logic       last;
  } exp_t;

  logic            clk;
  logic [2:0]      rst_n;
  logic [2:0][7:0] din;
  logic [2:0][7:0] dout;
  logic [2:0]      vin, rdy_o, vout, rdy, fd;

  int checks   = 0;
  int failures = 0;
  int ncyc     = 0;
  int b_done   = 0;
  int c_inf    = 0;
  int a_fire_t[$];
  exp_t qa[$], qb[$], qc[$];
  bit pend[3];

  frame_framer #(.payload_bytes_p(4)) u_a (
    .clk_i(clk), .reset_ni(rst_n[0]), .data_i(din[0]), .valid_i(vin[0]),
    .ready_o(rdy_o[0]), .data_o(dout[0]), .valid_o(vout[0]),
    .ready_i(rdy[0]), .frame_done_o(fd[0]));

  frame_framer #(.payload_bytes_p(7)) u_b (
    .clk_i(clk), .reset_ni(rst_n[1]), .data_i(din[1]), .valid_i(vin[1]),
    .ready_o(rdy_o[1]), .data_o(dout[1]), .valid_o(vout[1]),
    .ready_i(rdy[1]), .frame_done_o(fd[1]));

  frame_framer #(.payload_bytes_p(1)) u_c (
    .clk_i(clk), .reset_ni(rst_n[2]), .data_i(din[2]), .valid_i(vin[2]),
    .ready_o(rdy_o[2]), .data_o(dout[2]), .valid_o(vout[2]),
    .ready_i(rdy[2]), .frame_done_o(fd[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int sb_size(input int i);
    case (i)
      0:       return qa.size();
      1:       return qb.size();
      default: return qc.size();
    endcase
  endfunction

  task automatic sb_push(input int i, input logic [7:0] b, input logic last);
    exp_t e;
    e.b = b;
    e.last = last;
    case (i)
      0:       qa.push_back(e);
      1:       qb.push_back(e);
      default: qc.push_back(e);
    endcase
  endtask

  function automatic exp_t sb_pop(input int i);
    case (i)
      0:       return qa.pop_front();
      1:       return qb.pop_front();
      default: return qc.pop_front();
    endcase
  endfunction

  // Output monitor: every accepted byte is popped and compared.
  always @(negedge clk) begin
    exp_t e;
    ncyc++;
    for (int i = 0; i < 3; i++) begin
      if (vout[i] && rdy[i]) begin
        if (sb_size(i) == 0) begin
          chk($sformatf("unexpected_byte%0d", i), 32'(dout[i]), 32'h100);
        end else begin
          e = sb_pop(i);
          chk($sformatf("data%0d", i), 32'(dout[i]), 32'(e.b));
          chk($sformatf("frame_done%0d", i), 32'(fd[i]), 32'(e.last));
        end
        if (i == 0) a_fire_t.push_back(ncyc);
        if (i == 1 && fd[1]) b_done++;
      end else begin
        chk($sformatf("frame_done_idle%0d", i), 32'(fd[i]), 32'd0);
      end
      if (i == 2 && vin[2] && rdy_o[2]) c_inf++;
    end
  end

  // Presents one byte and waits (bounded) until it is accepted.
  task automatic drive_byte(input int i, input logic [7:0] b, input bit rnd);
    bit got;
    int unsigned gap;
    got = 1'b0;
    if (rnd) begin
      gap = $urandom_range(0, 2);
      repeat (gap) begin
        @(posedge clk); #1;
        rdy[i] = 1'($urandom_range(0, 1));
      end
    end
    vin[i] = 1'b1;
    din[i] = b;
    for (int t = 0; t < 200 && !got; t++) begin
      @(negedge clk);
      if (rdy_o[i]) got = 1'b1;
      @(posedge clk); #1;
      if (rnd) rdy[i] = 1'($urandom_range(0, 1));
    end
    vin[i] = 1'b0;
    chk($sformatf("in_accept%0d", i), 32'(got), 32'd1);
  endtask

  // Queues the whole expected frame (plus the next header, which follows
  // unconditionally) and then feeds the payload.
  task automatic send_frame(input int i, input logic [63:0] bytes, input int n, input bit rnd);
    logic [7:0] s;
    s = '0;
    if (!pend[i]) begin
      sb_push(i, 8'hA5, 1'b0);
      sb_push(i, 8'h5A, 1'b0);
    end
    for (int k = 0; k < n; k++) begin
      s = s + bytes[8*k +: 8];
      sb_push(i, bytes[8*k +: 8], 1'b0);
    end
    sb_push(i, s, 1'b1);
    sb_push(i, 8'hA5, 1'b0);
    sb_push(i, 8'h5A, 1'b0);
    pend[i] = 1'b1;
    for (int k = 0; k < n; k++) drive_byte(i, bytes[8*k +: 8], rnd);
  endtask

  task automatic wait_drain(input int i, input bit rnd);
    for (int t = 0; t < 500 && sb_size(i) > 2; t++) begin
      @(posedge clk); #1;
      if (rnd) rdy[i] = 1'($urandom_range(0, 1));
    end
    chk($sformatf("drain%0d", i), 32'(sb_size(i)), 32'd2);
  endtask

  initial begin
    bit found;
    rst_n = '0;
    vin   = '0;
    din   = '0;
    rdy   = 3'b001;
    for (int i = 0; i < 3; i++) pend[i] = 1'b0;

    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rst_valid%0d", i), 32'(vout[i]), 32'd0);
      chk($sformatf("rst_data%0d", i), 32'(dout[i]), 32'd0);
      chk($sformatf("rst_ready%0d", i), 32'(rdy_o[i]), 32'd0);
      chk($sformatf("rst_done%0d", i), 32'(fd[i]), 32'd0);
    end
    repeat (2) @(posedge clk);
    #1 rst_n = '1;

    // Basic frame at full rate
    send_frame(0, 64'h04030201, 4, 1'b0);

    // Downstream backpressure on the sync1 byte of the next frame
    found = 1'b0;
    for (int t = 0; t < 20 && !found; t++) begin
      @(posedge clk); #1;
      if (vout[0] && dout[0] == 8'h5A) found = 1'b1;
    end
    chk("hold_reach", 32'(found), 32'd1);
    rdy[0] = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk("hold_data", 32'(dout[0]), 32'h5A);
      chk("hold_valid", 32'(vout[0]), 32'd1);
      chk("hold_ready", 32'(rdy_o[0]), 32'd0);
    end
    chk("no_gap", 32'(a_fire_t[6] - a_fire_t[0]), 32'd6);
    @(posedge clk); #1;
    rdy[0] = 1'b1;

    // Checksum wrap-around
    send_frame(0, 64'h03FFFFFF, 4, 1'b0);
    send_frame(0, 64'h000001FF, 4, 1'b0);
    wait_drain(0, 1'b0);

    // Asynchronous reset after payload byte 2 of 4
    sb_push(0, 8'h11, 1'b0);
    drive_byte(0, 8'h11, 1'b0);
    drive_byte(0, 8'h22, 1'b0);
    #1 rst_n[0] = 1'b0;
    #1;
    chk("midrst_valid", 32'(vout[0]), 32'd0);
    chk("midrst_data", 32'(dout[0]), 32'd0);
    chk("midrst_ready", 32'(rdy_o[0]), 32'd0);
    qa.delete();
    pend[0] = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n[0] = 1'b1;
    send_frame(0, 64'h08070605, 4, 1'b0);
    wait_drain(0, 1'b0);

    // Random stalls on both sides, 7-byte payload
    for (int f = 0; f < 20; f++) send_frame(1, {$urandom, $urandom}, 7, 1'b1);
    wait_drain(1, 1'b1);
    chk("b_frames", 32'(b_done), 32'd20);

    // Single-byte payload
    rdy[2] = 1'b1;
    send_frame(2, 64'h7E, 1, 1'b0);
    send_frame(2, 64'h7E, 1, 1'b0);
    wait_drain(2, 1'b0);
    repeat (4) @(negedge clk);
    chk("c_in_fires", 32'(c_inf), 32'd2);
    chk("c_idle_ready", 32'(rdy_o[2]), 32'd1);
    chk("c_idle_valid", 32'(vout[2]), 32'd0);
    chk("c_queue_empty", 32'(qc.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
